// File: rtl/seq_muldiv.sv
// Multi-cycle unsigned multiplier (shift-add, LSB first) and restoring divider
// (MSB first), one result bit per clock, behind a start/done handshake.
module seq_muldiv #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           op,
  input  logic [W-1:0]   i0,
  input  logic [W-1:0]   i1,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           div_by_zero,
  output logic           dbg_state
);

  // Handshake: start/op/i0/i1 are sampled on a rising edge only while idle
  // (busy=0); done pulses one cycle with result/div_by_zero valid and held
  // until the next completion. busy and done are never high together.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(W);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_q;
  logic [W-1:0]  opnd;   // multiplicand or divisor
  logic [W-1:0]  hi;     // product high half or partial remainder
  logic [W-1:0]  lo;     // multiplier bits / product low half, or dividend / quotient

  logic [W:0]    sum;
  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic [W-1:0]  hi_nxt;
  logic [W-1:0]  lo_nxt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    sum     = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {W{1'b0}})};
    shifted = {hi, lo[W-1]};
    diff    = shifted - {1'b0, opnd};
    cnt_nxt = cnt + CW'(1);
    hi_nxt  = '0;
    lo_nxt  = '0;
    if (op_q) begin
      // A set sign bit means the trial subtract went negative: restore.
      hi_nxt = diff[W] ? shifted[W-1:0] : diff[W-1:0];
      lo_nxt = {lo[W-2:0], ~diff[W]};
    end else begin
      hi_nxt = sum[W:1];
      lo_nxt = {sum[0], lo[W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= 1'b0;
      opnd        <= '0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            op_q  <= op;
            opnd  <= op ? i1 : i0;
            lo    <= op ? i0 : i1;
            hi    <= '0;
          end
        end
        S_RUN: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt_nxt;
          if (cnt_nxt == CNT_LAST) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            result      <= {hi_nxt, lo_nxt};
            div_by_zero <= op_q && (opnd == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = (state == S_RUN);

endmodule
